// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// The CPU bus pushes bytes into the FIFO. The transmit FSM pops them and
// serialises each one as 1 start bit, 8 data bits LSB-first, and 1 stop bit.
// While the FIFO holds data, frames are sent back to back with no idle gap.
// Note: sys_rst_n is active-high and asynchronous. The name is inherited
// from the surrounding SoC.

module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          txd
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int DIV_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    // Reject parameter sets that the bit timer or pointer wrap cannot handle.
    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx_fifo: BAUD_DIV (CLK_FREQ_HZ/BAUD) must be >= 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Transmitter state
    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] bit_cnt;
    logic [DIV_W-1:0] bit_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             txd_next;

    // A push is accepted only against the registered full flag. A pop in the
    // same cycle does not make room for a push that arrives while full.
    assign push = wr_en && !full;

    // Overflow is flagged for the whole cycle in which a push is being refused.
    assign ovf = wr_en && full;

    assign busy    = (state != IDLE);
    assign tx_done = (state == STOP) && (bit_cnt == DIV_LAST);

    // Occupancy after this edge. A simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Write the storage array. No reset is needed because the pointers guard validity.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Track the FIFO pointers, occupancy, and registered full/empty flags.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    // Next-state and datapath decisions for the serialiser.
    // Each bit is held for BAUD_DIV cycles. Leaving STOP with data waiting
    // pops immediately, so there is no idle gap between frames.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        txd_next     = txd;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr];
                    txd_next     = 1'b0;
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end

            START: begin
                if (bit_cnt == DIV_LAST) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_cnt == DIV_LAST) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = {1'b0, shift[7:1]};
                        txd_next     = shift[1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_cnt == DIV_LAST) begin
                    bit_cnt_next = '0;
                    if (!empty) begin
                        pop          = 1'b1;
                        shift_next   = mem[rd_ptr];
                        txd_next     = 1'b0;
                        bit_idx_next = '0;
                        state_next   = START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end

            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Register the serialiser state. Reset forces the line high at once and drops any partial frame.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            txd     <= txd_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks uart_tx_fifo against a frame-level reference model.
// The model keeps a byte queue and a frame position counter. Expected line
// levels come from bit position = frame cycle / BAUD_DIV.

module tb_uart_tx_fifo;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD        = 100_000;
    localparam int FIFO_DEPTH  = 4;
    localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD;
    localparam int FRAME       = 10 * BAUD_DIV;

    logic                          sys_clk = 1'b0;
    logic                          sys_rst_n = 1'b0;
    logic                          wr_en = 1'b0;
    logic [7:0]                    wr_data = 8'h00;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          ovf;
    logic                          busy;
    logic                          tx_done;
    logic                          txd;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle        = 0;

    // Reference model state
    logic [7:0] model_q [$];
    bit         model_active = 1'b0;
    int         model_pos    = 0;
    logic [7:0] model_byte   = 8'h00;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .busy      (busy),
        .tx_done   (tx_done),
        .txd       (txd)
    );

    // Free-running 10 ns clock
    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, actual, expected);
        end
    endtask

    function automatic logic model_txd();
        int b;
        if (!model_active) return 1'b1;
        b = model_pos / BAUD_DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return model_byte[b-1];
    endfunction

    task automatic check_all();
        check_output("txd",     32'(txd),     32'(model_txd()));
        check_output("busy",    32'(busy),    32'(model_active));
        check_output("tx_done", 32'(tx_done), 32'(model_active && (model_pos == FRAME - 1)));
        check_output("count",   32'(count),   32'(model_q.size()));
        check_output("full",    32'(full),    32'(model_q.size() == FIFO_DEPTH));
        check_output("empty",   32'(empty),   32'(model_q.size() == 0));
        check_output("ovf",     32'(ovf),     32'(wr_en && (model_q.size() == FIFO_DEPTH)));
    endtask

    // The model advances one clock edge using the FIFO contents from before that edge.
    task automatic model_edge(input bit we, input logic [7:0] d);
        bit         pre_full;
        bit         pre_empty;
        bit         do_pop;
        logic [7:0] popped;
        pre_full  = (model_q.size() == FIFO_DEPTH);
        pre_empty = (model_q.size() == 0);
        do_pop    = 1'b0;
        popped    = 8'h00;
        if (!pre_empty && (!model_active || model_pos == FRAME - 1)) begin
            do_pop = 1'b1;
            popped = model_q.pop_front();
        end
        if (we && !pre_full) model_q.push_back(d);
        if (model_active) begin
            if (model_pos == FRAME - 1) begin
                if (do_pop) begin
                    model_pos  = 0;
                    model_byte = popped;
                end else begin
                    model_active = 1'b0;
                end
            end else begin
                model_pos++;
            end
        end else if (do_pop) begin
            model_active = 1'b1;
            model_pos    = 0;
            model_byte   = popped;
        end
    endtask

    task automatic apply_stimulus(input bit we, input logic [7:0] d);
        @(negedge sys_clk);
        wr_en   = we;
        wr_data = d;
        #1;
        check_all();
        @(posedge sys_clk);
        model_edge(we, d);
        cycle++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00);
    endtask

    // Assert reset between clock edges and check that it takes effect without a clock.
    task automatic do_reset();
        #3;
        wr_en     = 1'b0;
        sys_rst_n = 1'b1;
        #1;
        model_q.delete();
        model_active = 1'b0;
        model_pos    = 0;
        check_output("rst_txd",     32'(txd),     32'd1);
        check_output("rst_busy",    32'(busy),    32'd0);
        check_output("rst_count",   32'(count),   32'd0);
        check_output("rst_full",    32'(full),    32'd0);
        check_output("rst_empty",   32'(empty),   32'd1);
        check_output("rst_ovf",     32'(ovf),     32'd0);
        check_output("rst_tx_done", 32'(tx_done), 32'd0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single 0xA5 frame from idle
        apply_stimulus(1'b1, 8'hA5);
        idle_cycles(FRAME + 10);

        // Two back-to-back frames "AB"
        apply_stimulus(1'b1, 8'h41);
        apply_stimulus(1'b1, 8'h42);
        idle_cycles(2 * FRAME + 10);

        // Fill past capacity, then hold wr_en across the pop with the FIFO full
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'h10 + 8'(i));
        for (int i = 0; i < FRAME + 20; i++) apply_stimulus(1'b1, 8'hC0 + 8'(i));
        idle_cycles(6 * FRAME);

        // Reset during data bit 3 of 0x00, then a clean 0x55 frame
        apply_stimulus(1'b1, 8'h00);
        idle_cycles(4 * BAUD_DIV + 3);
        do_reset();
        apply_stimulus(1'b1, 8'h55);
        idle_cycles(FRAME + 10);

        // All-ones byte: only the start bit is low
        apply_stimulus(1'b1, 8'hFF);
        idle_cycles(FRAME + 10);

        // Randomised traffic with occasional bursts
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                int len;
                len = int'($urandom_range(1, 7));
                for (int j = 0; j < len; j++) apply_stimulus(1'b1, 8'($urandom));
            end else begin
                apply_stimulus(r < 4, 8'($urandom));
            end
        end
        idle_cycles(6 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
